// File: rtl/aurora_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding one Aurora TX AXI stream from NUM_SRC sources.
// Optional mid-packet stall abort (TERM/FLUSH) is enabled by defining AURORA_TX_ARB_TIMEOUT_EN.
module aurora_tx_arbiter #(
  parameter int NUM_SRC        = 4,
  parameter int DATA_W         = 64,
  parameter int KEEP_W         = DATA_W / 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [NUM_SRC*DATA_W-1:0]   s_tdata,
  input  logic [NUM_SRC*KEEP_W-1:0]   s_tkeep,
  input  logic [NUM_SRC-1:0]          s_tvalid,
  input  logic [NUM_SRC-1:0]          s_tlast,
  output logic [NUM_SRC-1:0]          s_tready,
  output logic [DATA_W-1:0]           o_tdata,
  output logic [KEEP_W-1:0]           o_tkeep,
  output logic                        o_tvalid,
  output logic                        o_tlast,
  input  logic                        o_tready,
  output logic [NUM_SRC-1:0]          grant,
  output logic                        busy,
  output logic                        err_timeout
);

  localparam int IDX_W = $clog2(NUM_SRC);

  if (NUM_SRC < 2 || NUM_SRC > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("aurora_tx_arbiter: NUM_SRC must be 2..16 and TIMEOUT_CYCLES >= 1");
  end

`ifdef AURORA_TX_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, PASS, TERM, FLUSH} state_t;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] stall_cnt;
  logic             err_q;
`else
  typedef enum logic {IDLE, PASS} state_t;
`endif

  state_t           state;
  logic [IDX_W-1:0] last_src;
  logic [IDX_W-1:0] next_idx;
  logic             found;

  logic [DATA_W-1:0] sel_data;
  logic [KEEP_W-1:0] sel_keep;
  logic              sel_valid;
  logic              sel_last;

  // Search starts just after the previous winner and wraps, giving strict rotation.
  always_comb begin
    int unsigned cand;
    cand     = 0;
    found    = 1'b0;
    next_idx = last_src;
    for (int unsigned i = 1; i <= NUM_SRC; i++) begin
      cand = (32'(last_src) + i) % NUM_SRC;
      if (!found && s_tvalid[cand[IDX_W-1:0]]) begin
        found    = 1'b1;
        next_idx = cand[IDX_W-1:0];
      end
    end
  end

  // One-hot grant makes an AND-OR mux; it yields all zero while idle.
  always_comb begin
    sel_data  = '0;
    sel_keep  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (grant[k]) begin
        sel_data  = sel_data  | s_tdata[k*DATA_W +: DATA_W];
        sel_keep  = sel_keep  | s_tkeep[k*KEEP_W +: KEEP_W];
        sel_valid = sel_valid | s_tvalid[k];
        sel_last  = sel_last  | s_tlast[k];
      end
    end
  end

  always_comb begin
    o_tdata  = '0;
    o_tkeep  = '0;
    o_tvalid = 1'b0;
    o_tlast  = 1'b0;
    s_tready = '0;
    case (state)
      PASS: begin
        o_tdata  = sel_data;
        o_tkeep  = sel_keep;
        o_tvalid = sel_valid;
        o_tlast  = sel_last;
        s_tready = grant & {NUM_SRC{o_tready}};
      end
`ifdef AURORA_TX_ARB_TIMEOUT_EN
      TERM: begin
        o_tvalid = 1'b1;
        o_tlast  = 1'b1;
      end
      FLUSH: s_tready = grant;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      grant    <= '0;
      last_src <= IDX_W'(NUM_SRC - 1);
`ifdef AURORA_TX_ARB_TIMEOUT_EN
      stall_cnt <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
`ifdef AURORA_TX_ARB_TIMEOUT_EN
      err_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (enable && found) begin
            grant    <= NUM_SRC'(1) << next_idx;
            last_src <= next_idx;
            state    <= PASS;
          end
        end
        PASS: begin
          if (sel_valid && o_tready) begin
`ifdef AURORA_TX_ARB_TIMEOUT_EN
            stall_cnt <= '0;
`endif
            if (sel_last) begin
              grant <= '0;
              state <= IDLE;
            end
          end
`ifdef AURORA_TX_ARB_TIMEOUT_EN
          else if (!sel_valid) begin
            if (stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
              stall_cnt <= '0;
              err_q     <= 1'b1;
              state     <= TERM;
            end else begin
              stall_cnt <= stall_cnt + 1'b1;
            end
          end
`endif
        end
`ifdef AURORA_TX_ARB_TIMEOUT_EN
        TERM: begin
          if (o_tready) state <= FLUSH;
        end
        FLUSH: begin
          if (sel_valid && sel_last) begin
            grant <= '0;
            state <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

`ifdef AURORA_TX_ARB_TIMEOUT_EN
  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_aurora_tx_arbiter.sv
// Directed self-checking bench for aurora_tx_arbiter (4 sources, 16-bit data).
// Source k beat n carries data k*256+n; the timeout scenario runs only with AURORA_TX_ARB_TIMEOUT_EN.
module tb_aurora_tx_arbiter;

`ifdef AURORA_TX_ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 256;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [63:0] s_tdata;
  logic [7:0]  s_tkeep;
  logic [3:0]  s_tvalid;
  logic [3:0]  s_tlast;
  logic [3:0]  s_tready;
  logic [15:0] o_tdata;
  logic [1:0]  o_tkeep;
  logic        o_tvalid;
  logic        o_tlast;
  logic        o_tready;
  logic [3:0]  grant;
  logic        busy;
  logic        err_timeout;

  int unsigned len [4];
  int unsigned ptr [4];
  logic [3:0]  hold;
  logic        one_beat;
  int          n_cmp = 0;
  int          n_err = 0;

  aurora_tx_arbiter #(
    .NUM_SRC(4), .DATA_W(16), .KEEP_W(2), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(s_tready),
    .o_tdata(o_tdata), .o_tkeep(o_tkeep), .o_tvalid(o_tvalid), .o_tlast(o_tlast),
    .o_tready(o_tready),
    .grant(grant), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < 4; k++) begin
      s_tvalid[k]          = (ptr[k] < len[k]) && !hold[k];
      s_tlast[k]           = one_beat || (ptr[k] + 1 == len[k]);
      s_tdata[k*16 +: 16]  = 16'(k * 256 + ptr[k]);
      s_tkeep[k*2 +: 2]    = 2'b11;
    end
  endtask

  // Called at the negedge: latch handshakes, advance past the posedge, re-present sources.
  task automatic next();
    logic [3:0] fire;
    fire = s_tvalid & s_tready;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) if (fire[k]) ptr[k]++;
    drive();
  endtask

  task automatic out_chk(input string tag, input logic [3:0] g, input logic v,
                         input logic [15:0] d, input logic l);
    check({tag, " grant"}, grant, g);
    check({tag, " valid"}, o_tvalid, v);
    check({tag, " busy"}, busy, g != 4'b0);
    check({tag, " err"}, err_timeout, 1'b0);
    if (v) begin
      check({tag, " data"}, o_tdata, d);
      check({tag, " last"}, o_tlast, l);
      check({tag, " rdy"}, s_tready, g & {4{o_tready}});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; enable = 1'b0; o_tready = 1'b0; hold = '0; one_beat = 1'b0;
    for (int k = 0; k < 4; k++) begin len[k] = 0; ptr[k] = 0; end
    drive();
    #12;
    check("rst grant", grant, 4'b0);
    check("rst busy", busy, 1'b0);
    check("rst valid", o_tvalid, 1'b0);
    check("rst rdy", s_tready, 4'b0);
    check("rst err", err_timeout, 1'b0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // All four sources request continuously with single-beat packets.
    enable = 1'b1; o_tready = 1'b1; one_beat = 1'b1;
    for (int k = 0; k < 4; k++) begin len[k] = 2; ptr[k] = 0; end
    drive();
    for (int p = 0; p < 8; p++) begin
      @(negedge clk); out_chk($sformatf("rr arb%0d", p), 4'b0, 1'b0, 16'h0, 1'b0); next();
      @(negedge clk);
      out_chk($sformatf("rr pkt%0d", p), 4'(1 << (p % 4)), 1'b1, 16'((p % 4) * 256 + p / 4), 1'b1);
      next();
    end
    one_beat = 1'b0;

    // Sources 0 and 2 present 3-beat packets together: 8 cycles total.
    len[0] = 3; ptr[0] = 0; len[2] = 3; ptr[2] = 0;
    drive();
    @(negedge clk); out_chk("t1 arb0", 4'b0, 1'b0, 16'h0, 1'b0); next();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); out_chk($sformatf("t1 s0b%0d", i), 4'b0001, 1'b1, 16'(i), i == 2); next();
    end
    @(negedge clk); out_chk("t1 arb1", 4'b0, 1'b0, 16'h0, 1'b0); next();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); out_chk($sformatf("t1 s2b%0d", i), 4'b0100, 1'b1, 16'(16'h0200 + i), i == 2); next();
    end
    @(negedge clk); out_chk("t1 idle", 4'b0, 1'b0, 16'h0, 1'b0); next();

    // Source 1 4-beat packet with a 5-cycle backpressure on its second beat.
    len[1] = 4; ptr[1] = 0;
    drive();
    @(negedge clk); out_chk("t3 arb", 4'b0, 1'b0, 16'h0, 1'b0); next();
    @(negedge clk); out_chk("t3 b0", 4'b0010, 1'b1, 16'h0100, 1'b0); next();
    o_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); out_chk($sformatf("t3 stall%0d", i), 4'b0010, 1'b1, 16'h0101, 1'b0); next();
    end
    o_tready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk); out_chk($sformatf("t3 b%0d", i), 4'b0010, 1'b1, 16'(16'h0100 + i), i == 3); next();
    end
    @(negedge clk); out_chk("t3 idle", 4'b0, 1'b0, 16'h0, 1'b0); next();

    // enable gates new grants only; a packet in flight still completes.
    enable = 1'b0; len[3] = 3; ptr[3] = 0;
    drive();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); out_chk($sformatf("t4 gated%0d", i), 4'b0, 1'b0, 16'h0, 1'b0); next();
    end
    enable = 1'b1;
    @(negedge clk); out_chk("t4 arb", 4'b0, 1'b0, 16'h0, 1'b0); next();
    @(negedge clk); out_chk("t4 b0", 4'b1000, 1'b1, 16'h0300, 1'b0); next();
    enable = 1'b0; len[0] = 1; ptr[0] = 0;
    drive();
    @(negedge clk); out_chk("t4 b1", 4'b1000, 1'b1, 16'h0301, 1'b0); next();
    @(negedge clk); out_chk("t4 b2", 4'b1000, 1'b1, 16'h0302, 1'b1); next();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); out_chk($sformatf("t4 held%0d", i), 4'b0, 1'b0, 16'h0, 1'b0); next();
    end
    enable = 1'b1;
    @(negedge clk); out_chk("t4 arb2", 4'b0, 1'b0, 16'h0, 1'b0); next();
    @(negedge clk); out_chk("t4 s0", 4'b0001, 1'b1, 16'h0000, 1'b1); next();

    // Asynchronous reset mid-packet, then src0 beats a simultaneous src1.
    len[2] = 4; ptr[2] = 0;
    drive();
    @(negedge clk); out_chk("t5 arb", 4'b0, 1'b0, 16'h0, 1'b0); next();
    @(negedge clk); out_chk("t5 b0", 4'b0100, 1'b1, 16'h0200, 1'b0); next();
    #2 rst = 1'b0;
    #1;
    check("t5 rst grant", grant, 4'b0);
    check("t5 rst busy", busy, 1'b0);
    check("t5 rst valid", o_tvalid, 1'b0);
    check("t5 rst rdy", s_tready, 4'b0);
    len[2] = 0; len[0] = 1; ptr[0] = 0; len[1] = 1; ptr[1] = 0;
    drive();
    @(negedge clk) rst = 1'b1;
    out_chk("t5 rel", 4'b0, 1'b0, 16'h0, 1'b0); next();
    @(negedge clk); out_chk("t5 s0", 4'b0001, 1'b1, 16'h0000, 1'b1); next();
    @(negedge clk); out_chk("t5 arb2", 4'b0, 1'b0, 16'h0, 1'b0); next();
    @(negedge clk); out_chk("t5 s1", 4'b0010, 1'b1, 16'h0100, 1'b1); next();
    @(negedge clk); out_chk("t5 idle", 4'b0, 1'b0, 16'h0, 1'b0); next();

`ifdef AURORA_TX_ARB_TIMEOUT_EN
    // src0 stalls after 2 beats: abort with terminator, flush its tail, then src1.
    len[0] = 4; ptr[0] = 0; len[1] = 1; ptr[1] = 0;
    drive();
    @(negedge clk); out_chk("to arb", 4'b0, 1'b0, 16'h0, 1'b0); next();
    @(negedge clk); out_chk("to b0", 4'b0001, 1'b1, 16'h0000, 1'b0); next();
    @(negedge clk); out_chk("to b1", 4'b0001, 1'b1, 16'h0001, 1'b0); next();
    hold[0] = 1'b1;
    drive();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); out_chk($sformatf("to stall%0d", i), 4'b0001, 1'b0, 16'h0, 1'b0); next();
    end
    hold[0] = 1'b0;
    drive();
    @(negedge clk);
    check("to term err", err_timeout, 1'b1);
    check("to term valid", o_tvalid, 1'b1);
    check("to term last", o_tlast, 1'b1);
    check("to term keep", o_tkeep, 2'b00);
    check("to term data", o_tdata, 16'h0);
    check("to term rdy", s_tready, 4'b0);
    next();
    @(negedge clk);
    check("to flush err", err_timeout, 1'b0);
    check("to flush valid", o_tvalid, 1'b0);
    check("to flush rdy0", s_tready, 4'b0001);
    next();
    @(negedge clk); check("to flush rdy1", s_tready, 4'b0001); next();
    @(negedge clk); out_chk("to arb1", 4'b0, 1'b0, 16'h0, 1'b0); next();
    @(negedge clk); out_chk("to s1", 4'b0010, 1'b1, 16'h0100, 1'b1); next();
    check("to drained", 32'(ptr[0]), 32'd4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/aurora_tx_arbiter.md
Name: aurora_tx_arbiter

Overview:
- Packet-granular round-robin arbiter sharing one Aurora TX AXI stream between NUM_SRC requesters.
- Sits in front of the Aurora TX FIFO. Its output stream drives the FIFO input; the FIFO's ready-after-reset status drives `enable`.
- A grant is held from the first beat to the tlast beat of a packet, so packets from different sources never interleave.

Parameters:
- NUM_SRC, 4: number of requesting streams, 2..16.
- DATA_W, 64: AXI-S data width.
- KEEP_W, DATA_W/8: AXI-S keep width.
- TIMEOUT_CYCLES, 256: mid-packet stall limit. Used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- enable  in  1  downstream ready after reset. Gates new grants only.
- s_tdata  in  NUM_SRC*DATA_W  source data; source k occupies slice [k*DATA_W +: DATA_W].
- s_tkeep  in  NUM_SRC*KEEP_W  source keep.
- s_tvalid  in  NUM_SRC  source valid.
- s_tlast  in  NUM_SRC  source last.
- s_tready  out  NUM_SRC  source ready.
- o_tdata  out  DATA_W  output data.
- o_tkeep  out  KEEP_W  output keep.
- o_tvalid  out  1  output valid.
- o_tlast  out  1  output last.
- o_tready  in  1  output ready.
- grant  out  NUM_SRC  one-hot current grant; all zero when idle.
- busy  out  1  high while a packet is in progress.
- err_timeout  out  1  one-cycle pulse on stall abort. Tied 0 without the optional feature.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, grant=0, busy=0, err_timeout=0, o_tvalid=0, s_tready=0. Round-robin pointer last_src = NUM_SRC-1, so source 0 has top priority after reset.
- IDLE:
  - All s_tready=0 and o_tvalid=0.
  - When enable=1 and any s_tvalid=1, pick the first requester searching from last_src+1 upward, wrapping modulo NUM_SRC.
  - Register grant and last_src, then go to PASS.
  - No data moves in the arbitration cycle, giving one bubble cycle per packet.
- PASS:
  - Combinational passthrough of the granted source: o_tdata/o_tkeep/o_tlast/o_tvalid = s_*[g]; s_tready[g] = o_tready; all other s_tready=0.
  - A beat transfers when o_tvalid & o_tready.
  - A transfer with o_tlast=1 clears grant and busy and returns to IDLE. Arbitration can occur in the very next cycle.
  - A single-beat packet occupies exactly 2 cycles: arbitration plus transfer.
- enable deasserting mid-packet does not interrupt the packet. The current packet completes; no new grant is issued while enable=0.
- A source dropping s_tvalid mid-packet stalls the output (o_tvalid=0); the grant is held.
- Requests arriving during PASS wait; they are not lost.
- Simultaneous requests: round-robin order is strict. With all sources requesting continuously, the grant sequence is 0,1,2,3,0,...
- busy = (state != IDLE).
- Async reset mid-packet: the output stream is truncated with no tlast; downstream relies on its own reset.

Optional Feature:
- Macro: AURORA_TX_ARB_TIMEOUT_EN.
- Enabled:
  - Stall counter (width $clog2(TIMEOUT_CYCLES+1)) increments each PASS cycle in which s_tvalid[g]=0. It clears on any transfer and on leaving PASS.
  - On reaching TIMEOUT_CYCLES, go to TERM and pulse err_timeout for 1 cycle.
  - TERM: drive o_tvalid=1, o_tlast=1, o_tkeep=0, o_tdata=0 until o_tready; s_tready=0. Then go to FLUSH.
  - FLUSH: s_tready[g]=1, o_tvalid=0. Discard beats from source g through its tlast, then go to IDLE.
  - Reset and enable rules are unchanged.
- Disabled: no counter, no TERM or FLUSH states, err_timeout tied 0, and a stall holds the grant indefinitely.

Test Plan:
- Sources 0 and 2 each present a 3-beat packet at the same cycle, o_tready=1 -> src0's 3 beats, 1 bubble, src2's 3 beats. grant = 0001 then 0100. Total 8 cycles.
- All 4 sources request continuously with 1-beat packets -> grant order 0,1,2,3,0,1. Each packet takes 2 cycles, no starvation.
- src1 sends a 4-beat packet; o_tready=0 on beat 2 for 5 cycles -> data held stable, s_tready[1]=0 during the stall, no beat lost or duplicated.
- enable=0 with src3 valid -> no grant for 10 cycles. Set enable=1 -> grant=1000 on the next edge. Drop enable mid-packet -> the packet completes with tlast.
- Reset asserted mid-packet -> all outputs zero immediately. After release, src0 wins over a simultaneous src1 request.
- With AURORA_TX_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, src0 sends 2 beats then stalls 8 cycles -> err_timeout pulse, one terminator beat (tlast=1, tkeep=0), src0's late beats through tlast discarded, src1 then granted.
